// File: rtl/data_mem_slave_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
package data_mem_slave_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    localparam int unsigned DMEM_ADDR_W  = 10;
    localparam logic [3:0]  BYTE_EN_NONE = 4'b0000;

endpackage

// File: rtl/dmem_ram_bw.sv
// Single-port synchronous RAM, 4 byte-write lanes, registered read port.
module dmem_ram_bw
    import data_mem_slave_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data only moves on a read; writes leave the last read word visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en && (we == BYTE_EN_NONE)) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_slave.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, performs the
// access, pulses drdy and stalls the pipeline while the access is pending.
module data_mem_slave
    import data_mem_slave_pkg::*;
#(
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dce,
    input  logic [3:0]  dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        drdy,
    output logic        stall_req
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              drdy_q;

    logic              acc_en;
    logic [ADDR_W-1:0] acc_idx;
    logic [3:0]        acc_we;
    logic [31:0]       acc_wdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{daddr[31:ADDR_W+2], daddr[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        acc_en    = 1'b0;
        acc_idx   = idx_q;
        acc_we    = we_q;
        acc_wdata = wdata_q;
        stall_req = 1'b0;

        unique case (state_q)
            DMEM_IDLE: begin
                if (dce) begin
                    stall_req = 1'b1;
                    idx_d     = daddr[ADDR_W+1:2];
                    we_d      = dwe;
                    wdata_d   = din;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the accept edge is also the access edge.
                        state_d   = DMEM_DONE;
                        acc_en    = 1'b1;
                        acc_idx   = daddr[ADDR_W+1:2];
                        acc_we    = dwe;
                        acc_wdata = din;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            DMEM_WAIT: begin
                stall_req = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DMEM_DONE;
                    acc_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // dce still carries the same instruction here, so it is not re-accepted.
            DMEM_DONE: begin
                state_d = DMEM_IDLE;
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            drdy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            drdy_q  <= acc_en;
        end
    end

    dmem_ram_bw #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (acc_en),
        .we   (acc_we),
        .addr (acc_idx),
        .wdata(acc_wdata),
        .rdata(dout)
    );

    assign drdy = drdy_q;

endmodule

// File: tb/tb_data_mem_slave.sv
// Directed bench for data_mem_slave built with 0, 1 and 3 wait states.
module tb_data_mem_slave;

    logic        clk;
    logic        rst_n     [3];
    logic        dce       [3];
    logic [3:0]  dwe       [3];
    logic [31:0] daddr     [3];
    logic [31:0] din       [3];
    logic [31:0] dout      [3];
    logic        drdy      [3];
    logic        stall_req [3];

    int checks   = 0;
    int failures = 0;

    // Index 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=1, 2: WAIT_CYCLES=3.
    data_mem_slave #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n[0]), .dce(dce[0]), .dwe(dwe[0]), .daddr(daddr[0]),
        .din(din[0]), .dout(dout[0]), .drdy(drdy[0]), .stall_req(stall_req[0])
    );
    data_mem_slave #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n[1]), .dce(dce[1]), .dwe(dwe[1]), .daddr(daddr[1]),
        .din(din[1]), .dout(dout[1]), .drdy(drdy[1]), .stall_req(stall_req[1])
    );
    data_mem_slave #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst_n(rst_n[2]), .dce(dce[2]), .dwe(dwe[2]), .daddr(daddr[2]),
        .din(din[2]), .dout(dout[2]), .drdy(drdy[2]), .stall_req(stall_req[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request on DUT k; inputs are scrambled after acceptance, dce held until DONE.
    task automatic req(input int k, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] data, input int lat, input string tag,
                       output logic [31:0] rd);
        int n;
        bit found;
        @(negedge clk);
        dce[k] = 1'b1; dwe[k] = we; daddr[k] = addr; din[k] = data;
        #1;
        check_eq({tag, " stall at request"}, 32'(stall_req[k]), 32'd1);
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (drdy[k]) begin
                found = 1'b1;
            end else begin
                check_eq({tag, " stall while waiting"}, 32'(stall_req[k]), 32'd1);
                dwe[k] = ~we; din[k] = ~data; daddr[k] = addr ^ 32'h4;
            end
        end
        check_eq({tag, " drdy seen"}, 32'(found), 32'd1);
        check_eq({tag, " latency"}, 32'(n), 32'(lat));
        check_eq({tag, " stall low in DONE"}, 32'(stall_req[k]), 32'd0);
        rd = dout[k];
        @(negedge clk);
        dce[k] = 1'b0; dwe[k] = 4'h0;
        @(posedge clk); #1;
        check_eq({tag, " drdy single pulse"}, 32'(drdy[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int np;
        int p0;
        int p1;

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; dce[k] = 1'b0; dwe[k] = 4'h0; daddr[k] = '0; din[k] = '0;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                check_eq("reset dout", dout[k], 32'h0);
                check_eq("reset drdy", 32'(drdy[k]), 32'd0);
                check_eq("reset stall", 32'(stall_req[k]), 32'd0);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(posedge clk); #1;
        check_eq("idle stall", 32'(stall_req[1]), 32'd0);

        // WAIT_CYCLES=1: full word, byte lane, aliasing
        req(1, 4'hF, 32'h10, 32'hDEADBEEF, 2, "w1 write 0x10", rd);
        req(1, 4'h0, 32'h10, 32'h0, 2, "w1 read 0x10", rd);
        check_eq("w1 read 0x10 data", rd, 32'hDEADBEEF);
        req(1, 4'hF, 32'h20, 32'h11223344, 2, "w1 preload 0x20", rd);
        check_eq("write leaves dout", rd, 32'hDEADBEEF);
        req(1, 4'b0010, 32'h20, 32'hAABBCCDD, 2, "w1 lane1 write", rd);
        req(1, 4'h0, 32'h20, 32'h0, 2, "w1 read 0x20", rd);
        check_eq("byte lane merge", rd, 32'h1122CC44);
        req(1, 4'b0011, 32'h20, 32'h99887766, 2, "w1 halfword write", rd);
        req(1, 4'h0, 32'h20, 32'h0, 2, "w1 read 0x20 again", rd);
        check_eq("halfword merge", rd, 32'h11227766);
        req(1, 4'hF, 32'h1000, 32'h12345678, 2, "w1 write 0x1000", rd);
        req(1, 4'h0, 32'h0, 32'h0, 2, "w1 read 0x0", rd);
        check_eq("alias 0x1000->0x0", rd, 32'h12345678);

        // Held dce through DONE: pulses only at cycles 2 and 5
        @(negedge clk);
        dce[1] = 1'b1; dwe[1] = 4'h0; daddr[1] = 32'h10; din[1] = '0;
        np = 0; p0 = 0; p1 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (drdy[1]) begin
                if (np == 0) p0 = c;
                else if (np == 1) p1 = c;
                np++;
            end
            if (c == 5) begin
                @(negedge clk);
                dce[1] = 1'b0;
            end
        end
        check_eq("held dce pulse count", 32'(np), 32'd2);
        check_eq("held dce first pulse", 32'(p0), 32'd2);
        check_eq("held dce second pulse", 32'(p1), 32'd5);
        check_eq("held dce read data", dout[1], 32'hDEADBEEF);

        // WAIT_CYCLES=0
        req(0, 4'hF, 32'h8, 32'hA5A50001, 1, "w0 write 0x8", rd);
        req(0, 4'h0, 32'h8, 32'h0, 1, "w0 read 0x8", rd);
        check_eq("w0 read data", rd, 32'hA5A50001);

        // WAIT_CYCLES=3, including reset in the middle of a write
        req(2, 4'hF, 32'h40, 32'h55AA55AA, 4, "w3 preload 0x40", rd);
        req(2, 4'h0, 32'h40, 32'h0, 4, "w3 read 0x40", rd);
        check_eq("w3 read data", rd, 32'h55AA55AA);
        @(negedge clk);
        dce[2] = 1'b1; dwe[2] = 4'hF; daddr[2] = 32'h40; din[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        #1;
        check_eq("mid reset drdy", 32'(drdy[2]), 32'd0);
        check_eq("mid reset dout", dout[2], 32'h0);
        dce[2] = 1'b0; dwe[2] = 4'h0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_eq("in reset drdy", 32'(drdy[2]), 32'd0);
        end
        @(negedge clk);
        rst_n[2] = 1'b1;
        req(2, 4'h0, 32'h40, 32'h0, 4, "w3 read after reset", rd);
        check_eq("aborted write not done", rd, 32'h55AA55AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
